// File: rtl/mem_bus_if.sv
// Data-bus handshake between the memory stage (master) and the memory system (slave).
// req/we/addr/sel/wdata stay stable from the request cycle until the single-cycle ack.
interface mem_bus_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (output req, we, addr, sel, wdata, input rdata, ack);
    modport slave  (input req, we, addr, sel, wdata, output rdata, ack);
endinterface

// File: rtl/mem_bus_stage.sv
// Memory-access stage: runs loads/stores/LL/SC over a req/ack data bus and forwards results to mem_wb.
// Optional bus timeout enabled by defining MEM_BUS_TIMEOUT_EN.
module mem_bus_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [4:0]  mem_wd_i,
    input  logic        mem_wreg_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [31:0] mem_hi_i,
    input  logic [31:0] mem_lo_i,
    input  logic        mem_whilo_i,
    input  logic [7:0]  mem_aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_reg2_i,
    input  logic        LLbit_i,
    input  logic        wb_LLbit_we_i,
    input  logic        wb_LLbit_value_i,
    mem_bus_if.master   bus,
    output logic        stall_req_o,
    output logic [4:0]  mem_wd_o,
    output logic        mem_wreg_o,
    output logic [31:0] mem_wdata_o,
    output logic [31:0] mem_hi_o,
    output logic [31:0] mem_lo_o,
    output logic        mem_whilo_o,
    output logic        mem_LLbit_we_o,
    output logic        mem_LLbit_value_o,
    output logic        bus_err_o
);

    localparam logic [7:0] OP_LB  = 8'b11100000;
    localparam logic [7:0] OP_LH  = 8'b11100001;
    localparam logic [7:0] OP_LW  = 8'b11100011;
    localparam logic [7:0] OP_LBU = 8'b11100100;
    localparam logic [7:0] OP_LHU = 8'b11100101;
    localparam logic [7:0] OP_SB  = 8'b11101000;
    localparam logic [7:0] OP_SH  = 8'b11101001;
    localparam logic [7:0] OP_SW  = 8'b11101011;
    localparam logic [7:0] OP_LL  = 8'b11110000;
    localparam logic [7:0] OP_SC  = 8'b11111000;
    localparam logic [4:0] NOP_REG_ADDR = 5'b00000;
    localparam logic       STOP = 1'b1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_n;
    logic        eff_llbit;
    logic        is_byte, is_half, is_load, is_store, is_mem, is_ll, is_sc;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_sel;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  sel_q;
    logic        we_q;
    logic        req_c, stall_c;
    logic        timeout_hit, to_err;
    logic        unused_stall_bits;

    assign unused_stall_bits = ^{stall[5], stall[3:0]};

    function automatic logic [31:0] load_extend(input logic [7:0] op, input logic [1:0] a,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'b00:   b = word[31:24];
            2'b01:   b = word[23:16];
            2'b10:   b = word[15:8];
            default: b = word[7:0];
        endcase
        h = a[1] ? word[15:0] : word[31:16];
        case (op)
            OP_LB:   return {{24{b[7]}}, b};
            OP_LBU:  return {24'b0, b};
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'b0, h};
            default: return word;
        endcase
    endfunction

    assign eff_llbit = wb_LLbit_we_i ? wb_LLbit_value_i : LLbit_i;
    assign is_ll     = (mem_aluop_i == OP_LL);
    assign is_sc     = (mem_aluop_i == OP_SC);
    assign is_mem    = is_load | is_store;

    always_comb begin
        is_byte  = 1'b0;
        is_half  = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        case (mem_aluop_i)
            OP_LB, OP_LBU: begin is_byte = 1'b1; is_load = 1'b1; end
            OP_LH, OP_LHU: begin is_half = 1'b1; is_load = 1'b1; end
            OP_LW, OP_LL:  is_load = 1'b1;
            OP_SB:         begin is_byte = 1'b1; is_store = 1'b1; end
            OP_SH:         begin is_half = 1'b1; is_store = 1'b1; end
            OP_SW:         is_store = 1'b1;
            OP_SC:         is_store = eff_llbit;
            default:       ;
        endcase
    end

    always_comb begin
        req_addr = {mem_addr_i[31:2], 2'b00};
        if (is_byte) begin
            req_sel   = 4'b1000 >> mem_addr_i[1:0];
            req_wdata = {4{mem_reg2_i[7:0]}};
        end else if (is_half) begin
            req_sel   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
            req_wdata = {2{mem_reg2_i[15:0]}};
        end else begin
            req_sel   = 4'b1111;
            req_wdata = mem_reg2_i;
        end
    end

    // Request fields are latched when the access launches so they cannot move while waiting for ack.
    always_ff @(posedge clk) begin
        if (state == IDLE && is_mem) begin
            addr_q  <= req_addr;
            sel_q   <= req_sel;
            wdata_q <= req_wdata;
            we_q    <= is_store;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        req_c   = 1'b0;
        stall_c = 1'b0;
        case (state)
            IDLE: begin
                if (is_mem) begin
                    req_c   = 1'b1;
                    stall_c = 1'b1;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                req_c   = 1'b1;
                stall_c = 1'b1;
                if (bus.ack || timeout_hit) state_n = DONE;
            end
            DONE: begin
                if (stall[4] != STOP) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= 32'b0;
        end else if (state == BUSY) begin
            if (bus.ack)         rdata_q <= bus.rdata;
            else if (timeout_hit) rdata_q <= 32'b0;
        end
    end

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] wait_cnt;
    logic             to_err_q;
    logic             bus_err_q;

    assign timeout_hit = (state == BUSY) && !bus.ack && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign to_err      = to_err_q && (state == DONE);
    assign bus_err_o   = bus_err_q;

    // to_err_q marks the instruction that timed out so its register/LLbit writes are suppressed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt  <= '0;
            to_err_q  <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            wait_cnt  <= (state == BUSY) ? wait_cnt + 1'b1 : '0;
            bus_err_q <= timeout_hit;
            if (timeout_hit)        to_err_q <= 1'b1;
            else if (state == IDLE) to_err_q <= 1'b0;
        end
    end
`else
    localparam int UNUSED_TIMEOUT = TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
    assign to_err      = 1'b0;
    assign bus_err_o   = 1'b0;
`endif

    assign bus.req     = rst & req_c;
    assign bus.we      = rst & req_c & ((state == BUSY) ? we_q : is_store);
    assign bus.addr    = (state == BUSY) ? addr_q  : req_addr;
    assign bus.sel     = (state == BUSY) ? sel_q   : req_sel;
    assign bus.wdata   = (state == BUSY) ? wdata_q : req_wdata;
    assign stall_req_o = rst & stall_c;

    always_comb begin
        mem_wd_o          = mem_wd_i;
        mem_wreg_o        = mem_wreg_i;
        mem_wdata_o       = mem_wdata_i;
        mem_hi_o          = mem_hi_i;
        mem_lo_o          = mem_lo_i;
        mem_whilo_o       = mem_whilo_i;
        mem_LLbit_we_o    = 1'b0;
        mem_LLbit_value_o = 1'b0;
        if (is_load) mem_wdata_o = load_extend(mem_aluop_i, mem_addr_i[1:0], rdata_q);
        if (is_ll) begin
            mem_LLbit_we_o    = 1'b1;
            mem_LLbit_value_o = 1'b1;
        end
        if (is_sc) begin
            mem_wdata_o    = {31'b0, eff_llbit};
            mem_LLbit_we_o = eff_llbit;
        end
        if (to_err) begin
            mem_wreg_o     = 1'b0;
            mem_LLbit_we_o = 1'b0;
        end
        if (!rst) begin
            mem_wd_o          = NOP_REG_ADDR;
            mem_wreg_o        = 1'b0;
            mem_wdata_o       = 32'b0;
            mem_hi_o          = 32'b0;
            mem_lo_o          = 32'b0;
            mem_whilo_o       = 1'b0;
            mem_LLbit_we_o    = 1'b0;
            mem_LLbit_value_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_bus_stage.sv
// Self-checking bench for mem_bus_stage: directed scenarios plus randomized accesses against a spec-level model.
module tb_mem_bus_stage;

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    localparam logic [7:0] LB = 8'b11100000, LH = 8'b11100001, LW = 8'b11100011;
    localparam logic [7:0] LBU = 8'b11100100, LHU = 8'b11100101;
    localparam logic [7:0] SB = 8'b11101000, SH = 8'b11101001, SW = 8'b11101011;
    localparam logic [7:0] LL = 8'b11110000, SC = 8'b11111000, NOP = 8'h00;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [4:0]  mem_wd_i;
    logic        mem_wreg_i, mem_whilo_i;
    logic [31:0] mem_wdata_i, mem_hi_i, mem_lo_i, mem_addr_i, mem_reg2_i;
    logic [7:0]  mem_aluop_i;
    logic        LLbit_i, wb_LLbit_we_i, wb_LLbit_value_i;
    logic        stall_req_o;
    logic [4:0]  mem_wd_o;
    logic        mem_wreg_o, mem_whilo_o, mem_LLbit_we_o, mem_LLbit_value_o, bus_err_o;
    logic [31:0] mem_wdata_o, mem_hi_o, mem_lo_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_bus_if bus_if();

    mem_bus_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .mem_wd_i(mem_wd_i), .mem_wreg_i(mem_wreg_i), .mem_wdata_i(mem_wdata_i),
        .mem_hi_i(mem_hi_i), .mem_lo_i(mem_lo_i), .mem_whilo_i(mem_whilo_i),
        .mem_aluop_i(mem_aluop_i), .mem_addr_i(mem_addr_i), .mem_reg2_i(mem_reg2_i),
        .LLbit_i(LLbit_i), .wb_LLbit_we_i(wb_LLbit_we_i), .wb_LLbit_value_i(wb_LLbit_value_i),
        .bus(bus_if),
        .stall_req_o(stall_req_o),
        .mem_wd_o(mem_wd_o), .mem_wreg_o(mem_wreg_o), .mem_wdata_o(mem_wdata_o),
        .mem_hi_o(mem_hi_o), .mem_lo_o(mem_lo_o), .mem_whilo_o(mem_whilo_o),
        .mem_LLbit_we_o(mem_LLbit_we_o), .mem_LLbit_value_o(mem_LLbit_value_o),
        .bus_err_o(bus_err_o)
    );

    // ---------------- reference model ----------------
    function automatic int m_size(input logic [7:0] op);
        if (op == LB || op == LBU || op == SB) return 1;
        if (op == LH || op == LHU || op == SH) return 2;
        return 4;
    endfunction

    function automatic bit m_is_store(input logic [7:0] op);
        return (op == SB) || (op == SH) || (op == SW) || (op == SC);
    endfunction

    function automatic logic [3:0] m_sel(input logic [7:0] op, input logic [31:0] a);
        int idx;
        idx = int'(a % 4);
        if (m_size(op) == 1) return 4'(1 << (3 - idx));
        if (m_size(op) == 2) return (idx >= 2) ? 4'd3 : 4'd12;
        return 4'd15;
    endfunction

    function automatic logic [31:0] m_bus_wdata(input logic [7:0] op, input logic [31:0] r);
        if (m_size(op) == 1) return (r & 32'hFF) * 32'h01010101;
        if (m_size(op) == 2) return (r & 32'hFFFF) * 32'h00010001;
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] a,
                                           input logic [31:0] rd);
        logic [31:0] v;
        int idx;
        idx = int'(a % 4);
        if (m_size(op) == 1) begin
            v = (rd >> (8 * (3 - idx))) & 32'hFF;
            if (op == LB && v >= 32'd128) v = v - 32'd256;
            return v;
        end
        if (m_size(op) == 2) begin
            v = (idx >= 2) ? (rd & 32'hFFFF) : (rd >> 16);
            if (op == LH && v >= 32'd32768) v = v - 32'd65536;
            return v;
        end
        return rd;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic do_access(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                             input logic [31:0] rd, input int ack_at,
                             output int req_cnt, output int stall_cnt, output logic stable,
                             output logic [3:0] sel0, output logic [31:0] addr0,
                             output logic [31:0] wdata0, output logic we0, output logic hung);
        @(negedge clk);
        mem_aluop_i = op;
        mem_addr_i  = addr;
        mem_reg2_i  = reg2;
        bus_if.ack  = 1'b0;
        req_cnt = 0; stall_cnt = 0; stable = 1'b1; hung = 1'b1;
        sel0 = '0; addr0 = '0; wdata0 = '0; we0 = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (c > 0) begin
                @(negedge clk);
                bus_if.ack = 1'b0;
            end
            #1;
            if (c > 0 && !bus_if.req) begin
                hung = 1'b0;
                break;
            end
            if (bus_if.req) req_cnt++;
            if (stall_req_o) stall_cnt++;
            if (c == 0) begin
                sel0 = bus_if.sel; addr0 = bus_if.addr; wdata0 = bus_if.wdata; we0 = bus_if.we;
            end else if (bus_if.sel !== sel0 || bus_if.addr !== addr0 ||
                         bus_if.wdata !== wdata0 || bus_if.we !== we0) begin
                stable = 1'b0;
            end
            if (c == ack_at + 1) begin
                bus_if.ack   = 1'b1;
                bus_if.rdata = rd;
            end else begin
                bus_if.rdata = $urandom;
            end
        end
    endtask

    task automatic finish_op();
        mem_aluop_i = NOP;
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0; stall = '0;
        mem_wd_i = 5'd9; mem_wreg_i = 1'b1; mem_wdata_i = 32'h11111111;
        mem_hi_i = 32'h22222222; mem_lo_i = 32'h33333333; mem_whilo_i = 1'b1;
        mem_aluop_i = LL; mem_addr_i = 32'h100; mem_reg2_i = 32'h0;
        LLbit_i = 1'b0; wb_LLbit_we_i = 1'b0; wb_LLbit_value_i = 1'b0;
        bus_if.ack = 1'b0; bus_if.rdata = 32'h0;
        #1;
        checks++; if (bus_if.req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", bus_if.req); end
        checks++; if (stall_req_o !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall_req_o); end
        checks++; if (mem_wd_o !== 5'd0) begin errors++; $display("FAIL reset_wd got=%0d exp=0", mem_wd_o); end
        checks++; if (mem_wreg_o !== 1'b0 || mem_whilo_o !== 1'b0) begin errors++; $display("FAIL reset_we got=%b%b exp=00", mem_wreg_o, mem_whilo_o); end
        checks++; if (mem_wdata_o !== 32'h0 || mem_hi_o !== 32'h0 || mem_lo_o !== 32'h0) begin errors++; $display("FAIL reset_data got=%h/%h/%h exp=0", mem_wdata_o, mem_hi_o, mem_lo_o); end
        checks++; if (mem_LLbit_we_o !== 1'b0) begin errors++; $display("FAIL reset_llwe got=%b exp=0", mem_LLbit_we_o); end
        checks++; if (bus_err_o !== 1'b0) begin errors++; $display("FAIL reset_buserr got=%b exp=0", bus_err_o); end
        mem_aluop_i = NOP;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_passthrough();
        logic [7:0] ops [4];
        ops = '{8'h25, 8'h21, 8'h00, 8'h2A};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_aluop_i = ops[i];
            mem_wd_i = 5'($urandom); mem_wreg_i = 1'($urandom); mem_whilo_i = 1'($urandom);
            mem_wdata_i = $urandom; mem_hi_i = $urandom; mem_lo_i = $urandom; mem_addr_i = $urandom;
            #1;
            checks++;
            if (mem_wd_o !== mem_wd_i || mem_wreg_o !== mem_wreg_i || mem_wdata_o !== mem_wdata_i ||
                mem_hi_o !== mem_hi_i || mem_lo_o !== mem_lo_i || mem_whilo_o !== mem_whilo_i ||
                mem_LLbit_we_o !== 1'b0 || bus_if.req !== 1'b0 || stall_req_o !== 1'b0) begin
                errors++;
                $display("FAIL passthrough op=%h got wdata=%h req=%b stall=%b llwe=%b exp wdata=%h req=0 stall=0 llwe=0",
                         ops[i], mem_wdata_o, bus_if.req, stall_req_o, mem_LLbit_we_o, mem_wdata_i);
            end
        end
        mem_wreg_i = 1'b1; mem_wd_i = 5'd7;
    endtask

    task automatic test_load_word();
        int rq, st; logic stb, hung, we0; logic [3:0] s0; logic [31:0] a0, w0;
        do_access(LW, 32'h100, 32'h0, 32'hDEADBEEF, 2, rq, st, stb, s0, a0, w0, we0, hung);
        checks++; if (hung !== 1'b0) begin errors++; $display("FAIL lw_ack got=no_completion exp=completion"); end
        checks++; if (rq != 4) begin errors++; $display("FAIL lw_req_cycles got=%0d exp=4", rq); end
        checks++; if (st != 4) begin errors++; $display("FAIL lw_stall_cycles got=%0d exp=4", st); end
        checks++; if (a0 !== 32'h100 || s0 !== 4'b1111 || we0 !== 1'b0 || stb !== 1'b1) begin errors++; $display("FAIL lw_bus got addr=%h sel=%b we=%b stable=%b exp 100/1111/0/1", a0, s0, we0, stb); end
        checks++; if (mem_wdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got=%h exp=deadbeef", mem_wdata_o); end
        checks++; if (stall_req_o !== 1'b0 || mem_wreg_o !== 1'b1 || mem_wd_o !== 5'd7) begin errors++; $display("FAIL lw_done got stall=%b wreg=%b wd=%0d exp 0/1/7", stall_req_o, mem_wreg_o, mem_wd_o); end
        finish_op();
    endtask

    task automatic test_byte_half_loads();
        int rq, st; logic stb, hung, we0; logic [3:0] s0; logic [31:0] a0, w0;
        do_access(LB, 32'h103, 32'h0, 32'h123456F0, 0, rq, st, stb, s0, a0, w0, we0, hung);
        checks++; if (s0 !== 4'b0001 || a0 !== 32'h100) begin errors++; $display("FAIL lb_sel got sel=%b addr=%h exp 0001/100", s0, a0); end
        checks++; if (mem_wdata_o !== 32'hFFFFFFF0) begin errors++; $display("FAIL lb_data got=%h exp=fffffff0", mem_wdata_o); end
        finish_op();
        do_access(LBU, 32'h103, 32'h0, 32'h123456F0, 1, rq, st, stb, s0, a0, w0, we0, hung);
        checks++; if (mem_wdata_o !== 32'h000000F0) begin errors++; $display("FAIL lbu_data got=%h exp=000000f0", mem_wdata_o); end
        finish_op();
        do_access(LH, 32'h500, 32'h0, 32'h8001ABCD, 0, rq, st, stb, s0, a0, w0, we0, hung);
        checks++; if (s0 !== 4'b1100 || mem_wdata_o !== 32'hFFFF8001) begin errors++; $display("FAIL lh_data got sel=%b data=%h exp 1100/ffff8001", s0, mem_wdata_o); end
        finish_op();
    endtask

    task automatic test_store_half();
        int rq, st; logic stb, hung, we0; logic [3:0] s0; logic [31:0] a0, w0;
        mem_wdata_i = 32'h0;
        do_access(SH, 32'h202, 32'h0000ABCD, 32'h0, 1, rq, st, stb, s0, a0, w0, we0, hung);
        checks++; if (s0 !== 4'b0011 || we0 !== 1'b1 || a0 !== 32'h200) begin errors++; $display("FAIL sh_bus got sel=%b we=%b addr=%h exp 0011/1/200", s0, we0, a0); end
        checks++; if (w0 !== 32'hABCDABCD || stb !== 1'b1) begin errors++; $display("FAIL sh_wdata got=%h stable=%b exp=abcdabcd/1", w0, stb); end
        finish_op();
    endtask

    task automatic test_llsc();
        int rq, st; logic stb, hung, we0; logic [3:0] s0; logic [31:0] a0, w0;
        do_access(LL, 32'h300, 32'h0, 32'h11223344, 0, rq, st, stb, s0, a0, w0, we0, hung);
        checks++; if (mem_wdata_o !== 32'h11223344 || mem_LLbit_we_o !== 1'b1 || mem_LLbit_value_o !== 1'b1) begin errors++; $display("FAIL ll_done got data=%h llwe=%b llval=%b exp 11223344/1/1", mem_wdata_o, mem_LLbit_we_o, mem_LLbit_value_o); end
        finish_op();
        // SC while writeback is clearing the LLbit: must fail without a bus access
        @(negedge clk);
        LLbit_i = 1'b1; wb_LLbit_we_i = 1'b1; wb_LLbit_value_i = 1'b0;
        mem_aluop_i = SC; mem_addr_i = 32'h300; mem_reg2_i = 32'h77;
        #1;
        checks++; if (bus_if.req !== 1'b0 || stall_req_o !== 1'b0) begin errors++; $display("FAIL sc_fail_req got req=%b stall=%b exp 0/0", bus_if.req, stall_req_o); end
        checks++; if (mem_wdata_o !== 32'h0 || mem_LLbit_we_o !== 1'b0) begin errors++; $display("FAIL sc_fail_out got data=%h llwe=%b exp 0/0", mem_wdata_o, mem_LLbit_we_o); end
        @(negedge clk); #1;
        checks++; if (bus_if.req !== 1'b0) begin errors++; $display("FAIL sc_fail_next got req=%b exp 0", bus_if.req); end
        mem_aluop_i = NOP;
        // SC succeeding via the LLbit forwarded from writeback
        LLbit_i = 1'b0; wb_LLbit_we_i = 1'b1; wb_LLbit_value_i = 1'b1;
        do_access(SC, 32'h304, 32'hCAFE0001, 32'h0, 1, rq, st, stb, s0, a0, w0, we0, hung);
        checks++; if (rq != 3 || s0 !== 4'b1111 || we0 !== 1'b1 || w0 !== 32'hCAFE0001) begin errors++; $display("FAIL sc_ok_bus got req=%0d sel=%b we=%b wdata=%h exp 3/1111/1/cafe0001", rq, s0, we0, w0); end
        checks++; if (mem_wdata_o !== 32'h1 || mem_LLbit_we_o !== 1'b1 || mem_LLbit_value_o !== 1'b0) begin errors++; $display("FAIL sc_ok_out got data=%h llwe=%b llval=%b exp 1/1/0", mem_wdata_o, mem_LLbit_we_o, mem_LLbit_value_o); end
        finish_op();
        LLbit_i = 1'b0; wb_LLbit_we_i = 1'b0; wb_LLbit_value_i = 1'b0;
    endtask

    task automatic test_done_hold();
        int rq, st; logic stb, hung, we0; logic [3:0] s0; logic [31:0] a0, w0;
        do_access(LW, 32'h700, 32'h0, 32'hCAFEF00D, 1, rq, st, stb, s0, a0, w0, we0, hung);
        stall = 6'b010000;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus_if.ack = 1'b1; bus_if.rdata = 32'h0BADBAD0;
            #1;
            checks++;
            if (bus_if.req !== 1'b0 || stall_req_o !== 1'b0 || mem_wdata_o !== 32'hCAFEF00D) begin
                errors++;
                $display("FAIL done_hold cyc=%0d got req=%b stall=%b data=%h exp 0/0/cafef00d", i, bus_if.req, stall_req_o, mem_wdata_o);
            end
        end
        bus_if.ack = 1'b0;
        stall = 6'b000000;
        @(negedge clk); #1;
        checks++; if (bus_if.req !== 1'b1) begin errors++; $display("FAIL done_release got req=%b exp 1", bus_if.req); end
        mem_aluop_i = NOP;
        #1;
        checks++; if (bus_if.req !== 1'b0) begin errors++; $display("FAIL done_release_nop got req=%b exp 0", bus_if.req); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        int rq, st; logic stb, hung, we0; logic [3:0] s0; logic [31:0] a0, w0;
        @(negedge clk);
        mem_aluop_i = LW; mem_addr_i = 32'h400;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus_if.req !== 1'b1) begin errors++; $display("FAIL rstmid_busy got req=%b exp 1", bus_if.req); end
        rst = 1'b0;
        #1;
        checks++; if (bus_if.req !== 1'b0 || stall_req_o !== 1'b0 || mem_wreg_o !== 1'b0) begin errors++; $display("FAIL rstmid_drop got req=%b stall=%b wreg=%b exp 0/0/0", bus_if.req, stall_req_o, mem_wreg_o); end
        mem_aluop_i = NOP;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus_if.ack = 1'b1; bus_if.rdata = 32'h55555555;
        @(negedge clk);
        bus_if.ack = 1'b0;
        #1;
        checks++; if (bus_if.req !== 1'b0 || stall_req_o !== 1'b0) begin errors++; $display("FAIL rstmid_lateack got req=%b stall=%b exp 0/0", bus_if.req, stall_req_o); end
        do_access(LW, 32'h404, 32'h0, 32'h600DF00D, 0, rq, st, stb, s0, a0, w0, we0, hung);
        checks++; if (rq != 2 || mem_wdata_o !== 32'h600DF00D) begin errors++; $display("FAIL rstmid_next got req=%0d data=%h exp 2/600df00d", rq, mem_wdata_o); end
        finish_op();
    endtask

    task automatic test_random();
        logic [7:0] ops [9];
        logic [7:0] op; logic [31:0] addr, reg2, rd, exp_data;
        int lat, rq, st; logic stb, hung, we0; logic [3:0] s0; logic [31:0] a0, w0;
        ops = '{LB, LBU, LH, LHU, LW, SB, SH, SW, LL};
        for (int i = 0; i < 24; i++) begin
            op = ops[$urandom_range(0, 8)];
            addr = $urandom; reg2 = $urandom; rd = $urandom; lat = $urandom_range(0, 3);
            mem_wdata_i = $urandom;
            do_access(op, addr, reg2, rd, lat, rq, st, stb, s0, a0, w0, we0, hung);
            exp_data = m_is_store(op) ? mem_wdata_i : m_load(op, addr, rd);
            checks++;
            if (hung !== 1'b0 || rq != lat + 2 || st != lat + 2 || stb !== 1'b1) begin
                errors++;
                $display("FAIL rand_timing op=%h got req=%0d stall=%0d stable=%b hung=%b exp %0d/%0d/1/0", op, rq, st, stb, hung, lat + 2, lat + 2);
            end
            checks++;
            if (s0 !== m_sel(op, addr) || a0 !== (addr & 32'hFFFFFFFC) || we0 !== m_is_store(op) ||
                (m_is_store(op) && w0 !== m_bus_wdata(op, reg2))) begin
                errors++;
                $display("FAIL rand_bus op=%h addr=%h got sel=%b a=%h we=%b wd=%h exp sel=%b we=%b wd=%h",
                         op, addr, s0, a0, we0, w0, m_sel(op, addr), m_is_store(op), m_bus_wdata(op, reg2));
            end
            checks++;
            if (mem_wdata_o !== exp_data || stall_req_o !== 1'b0) begin
                errors++;
                $display("FAIL rand_result op=%h addr=%h rd=%h got=%h exp=%h stall=%b", op, addr, rd, mem_wdata_o, exp_data, stall_req_o);
            end
            finish_op();
        end
    endtask

`ifdef MEM_BUS_TIMEOUT_EN
    task automatic test_timeout();
        int rq, st; logic stb, hung, we0; logic [3:0] s0; logic [31:0] a0, w0;
        do_access(LL, 32'h800, 32'h0, 32'h0, 1000, rq, st, stb, s0, a0, w0, we0, hung);
        checks++; if (hung !== 1'b0) begin errors++; $display("FAIL to_end got=no_completion exp=completion"); end
        checks++; if (bus_err_o !== 1'b1 || mem_wreg_o !== 1'b0 || mem_LLbit_we_o !== 1'b0 || mem_wdata_o !== 32'h0) begin errors++; $display("FAIL to_done got err=%b wreg=%b llwe=%b data=%h exp 1/0/0/0", bus_err_o, mem_wreg_o, mem_LLbit_we_o, mem_wdata_o); end
        stall = 6'b010000;
        @(negedge clk); #1;
        checks++; if (bus_err_o !== 1'b0 || mem_wreg_o !== 1'b0) begin errors++; $display("FAIL to_pulse got err=%b wreg=%b exp 0/0", bus_err_o, mem_wreg_o); end
        stall = 6'b000000;
        finish_op();
    endtask
`endif

    initial begin
        test_reset();
        test_passthrough();
        test_load_word();
        test_byte_half_loads();
        test_store_half();
        test_llsc();
        test_done_hold();
        test_reset_mid_access();
        test_random();
`ifdef MEM_BUS_TIMEOUT_EN
        test_timeout();
`endif
        checks++; if (bus_err_o !== 1'b0) begin errors++; $display("FAIL final_buserr got=%b exp=0", bus_err_o); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=time_limit exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
